// File: rtl/upsample_pkg.sv
// Shared types and width helpers for the interpolating upsampler.
package upsample_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Accumulator width: sample, N fractional bits, one guard/sign bit.
  function automatic int unsigned acc_w(input int unsigned width, input int unsigned n);
    return width + n + 1;
  endfunction

  // Signed difference of two samples needs one extra bit.
  function automatic int unsigned delta_w(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/upsample_ramp.sv
// Upsampler datapath: per-burst delta, ramp accumulator and output truncation.
// UPSAMPLE_INTERP_LINEAR_EN selects the linear ramp; otherwise a zero-order hold.
module upsample_ramp
  import upsample_pkg::*;
#(
  parameter int unsigned WIDTH = 32
`ifdef UPSAMPLE_INTERP_LINEAR_EN
  ,
  parameter int unsigned N     = 1,
  parameter int unsigned SIG   = 0
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
`ifdef UPSAMPLE_INTERP_LINEAR_EN
  input  logic             step,
`endif
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] data
);

`ifdef UPSAMPLE_INTERP_LINEAR_EN
  localparam int unsigned DW = delta_w(WIDTH);
  localparam int unsigned AW = acc_w(WIDTH, N);

  logic [WIDTH-1:0]     prev;
  logic                 prev_vld;
  logic [WIDTH-1:0]     base;
  logic signed [DW-1:0] x_ext;
  logic signed [DW-1:0] base_ext;
  logic signed [DW-1:0] delta;
  logic signed [DW-1:0] delta_q;
  logic signed [AW-1:0] acc_base;
  logic signed [AW-1:0] acc;
  logic                 unused_acc_bits;

  // The first sample after reset has no predecessor, so it ramps from itself.
  assign base     = prev_vld ? prev : x;
  assign x_ext    = (SIG != 0) ? {x[WIDTH-1], x} : {1'b0, x};
  assign base_ext = (SIG != 0) ? {base[WIDTH-1], base} : {1'b0, base};
  assign delta    = x_ext - base_ext;
  assign acc_base = AW'(base_ext) <<< N;

  // Load starts the ramp at beat 1; step advances one beat; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      delta_q  <= '0;
      prev     <= '0;
      prev_vld <= 1'b0;
    end else if (load) begin
      acc      <= acc_base + AW'(delta);
      delta_q  <= delta;
      prev     <= x;
      prev_vld <= 1'b1;
    end else if (step) begin
      acc      <= acc + AW'(delta_q);
    end
  end

  // Dropping the N fraction bits is an arithmetic shift with floor rounding.
  assign data            = acc[N +: WIDTH];
  assign unused_acc_bits = ^acc;
`else
  logic [WIDTH-1:0] hold_q;

  // Every beat of a burst repeats the accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (load) begin
      hold_q <= x;
    end
  end

  assign data = hold_q;
`endif

endmodule

// File: rtl/upsample_interp.sv
// Interpolating upsampler: one input sample expands into a burst of 2^N beats.
// Define UPSAMPLE_INTERP_LINEAR_EN for linear interpolation; default is zero-order hold.
module upsample_interp
  import upsample_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 1,
  parameter int unsigned SIG   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  output logic             i_rdy,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last
);

  localparam int unsigned   CW       = (N > 0) ? N : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((1 << N) - 1);

  if (SIG > 1) begin : g_sig_check
    $error("upsample_interp: SIG must be 0 or 1");
  end

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          vld_nxt;
  logic          last_nxt;
  logic          accept;
  logic          beat_done;
  logic          load;
`ifdef UPSAMPLE_INTERP_LINEAR_EN
  logic          step;
`endif

  // A new sample can enter while idle or on the handshake of the final beat.
  assign beat_done = o_vld & o_rdy;
  assign i_rdy     = ~rst & ((state == IDLE) | (beat_done & o_last));
  assign accept    = i_vld & i_rdy;

  // Next-state, beat counter and control decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vld_nxt   = o_vld;
    last_nxt  = o_last;
    load      = 1'b0;
`ifdef UPSAMPLE_INTERP_LINEAR_EN
    step      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = EMIT;
          cnt_nxt   = '0;
          vld_nxt   = 1'b1;
          last_nxt  = (N == 0);
          load      = 1'b1;
        end
      end
      EMIT: begin
        if (beat_done) begin
          if (o_last) begin
            if (accept) begin
              state_nxt = EMIT;
              cnt_nxt   = '0;
              vld_nxt   = 1'b1;
              last_nxt  = (N == 0);
              load      = 1'b1;
            end else begin
              state_nxt = IDLE;
              vld_nxt   = 1'b0;
              last_nxt  = 1'b0;
            end
          end else begin
            cnt_nxt  = cnt + CW'(1);
            last_nxt = ((cnt + CW'(1)) == LAST_CNT);
`ifdef UPSAMPLE_INTERP_LINEAR_EN
            step     = 1'b1;
`endif
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
        last_nxt  = 1'b0;
      end
    endcase
  end

  // State, counter and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      o_vld  <= 1'b0;
      o_last <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      o_vld  <= vld_nxt;
      o_last <= last_nxt;
    end
  end

  upsample_ramp #(
    .WIDTH (WIDTH)
`ifdef UPSAMPLE_INTERP_LINEAR_EN
    ,
    .N     (N),
    .SIG   (SIG)
`endif
  ) u_ramp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
`ifdef UPSAMPLE_INTERP_LINEAR_EN
    .step (step),
`endif
    .x    (i_data),
    .data (o_data)
  );

endmodule

// File: doc/upsample_interp.md
# upsample_interp

Interpolating upsampler: accepts one sample per input handshake and emits a burst of 2^N output samples, either linearly interpolated from the previous accepted sample or held, depending on build configuration. It is the expanding counterpart of the averaging decimator in the computing cascade. It restores the pre-decimation sample rate for post-processing and DAC-side paths. Input and output both use valid/ready handshakes, and full throughput is one output beat per cycle.

## Interface
- WIDTH, 32: sample width in bits.
- N, 1: log2 of the interpolation factor. Burst length is 2^N. N=0 is legal and gives a registered pass-through.
- SIG, 0: 0 means unsigned samples; 1 means two's-complement samples.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_vld  in  1  input sample valid.
- i_rdy  out  1  block can accept a sample. Held 0 while rst=1.
- i_data  in  WIDTH  input sample.
- o_vld  out  1  output beat valid. Reset value 0.
- o_rdy  in  1  downstream accepts the beat.
- o_data  out  WIDTH  output sample. Reset value 0.
- o_last  out  1  marks the final beat of a burst. Reset value 0.

## Operation
- FSM states:
  - IDLE: no burst pending.
  - EMIT: burst in progress, beat counter cnt[N-1:0].
- Input accept happens when i_vld & i_rdy.
  - i_rdy = (state==IDLE) | (o_vld & o_rdy & o_last).
  - This is a combinational path from o_rdy to i_rdy, and it allows back-to-back bursts with no gap.
- On accept of sample x:
  - prev is the previous accepted sample.
  - delta = x − prev, computed at WIDTH+1 bits signed. Zero-extend when SIG=0; sign-extend when SIG=1.
  - Accumulator acc (WIDTH+N+1 bits, signed) loads prev<<N.
  - Go to EMIT with cnt=0.
- First sample after reset: prev is treated as equal to x, so delta=0 and the burst holds x.
- Beat j (1..2^N):
  - acc ← acc + delta.
  - o_data = acc >> N: arithmetic shift, floor rounding, low WIDTH bits.
  - The final beat always equals x exactly.
- o_last=1 on beat 2^N. After it is accepted:
  - prev ← x.
  - Go to IDLE, or straight into a new burst if an input is accepted in the same cycle.
- Backpressure: while o_vld & !o_rdy, o_data, o_last, acc and cnt hold unchanged.
- N=0: each accepted sample produces one beat with o_last=1 and o_data=x.
- Reset mid-burst:
  - Burst is aborted and o_vld=0 on the following cycle.
  - The prev-valid flag is cleared, so the next sample is again treated as the first.

## Timing
- Latency: sample accepted at edge t gives first beat with o_vld=1 after edge t (registered output). All outputs are registered.
- Burst occupies 2^N beats. The steady-state input rate is one sample per 2^N cycles when o_rdy=1.
- Simultaneous last-beat accept and new input accept: both take effect at the same edge, and the next cycle shows beat 1 of the new burst.
- Reset: 1-cycle rst clears o_vld, o_last, o_data, the FSM and the prev-valid flag. i_rdy=1 on the first cycle after rst deasserts.

## Configuration
- UPSAMPLE_INTERP_LINEAR_EN defined: linear interpolation as described above.
- UPSAMPLE_INTERP_LINEAR_EN undefined: zero-order hold.
  - All 2^N beats equal x.
  - delta, acc and prev logic is not synthesized.
  - Handshake, o_last and timing are identical to the linear build.

## Structure
- Package upsample_pkg holds:
  - state enum {IDLE, EMIT};
  - localparam helper function acc_w(WIDTH,N) = WIDTH+N+1;
  - delta width WIDTH+1.
- One sub-module, upsample_ramp, is the datapath: delta computation, accumulator and output truncation, with load/step/hold controls.
- The FSM, counter and handshake logic live in upsample_interp.

## Test plan
- WIDTH=8, N=2, SIG=0, linear, o_rdy=1.
  - Inputs 8 then 16 → beats 8,8,8,8 then 10,12,14,16.
  - o_last on beats 4 and 8.
- SIG=1, linear.
  - Inputs 16 then −16 → 16×4 then 8,0,−8,−16.
  - Inputs 0 then 3 (unsigned) → 0,1,2,3 (floor).
- Hold build (macro undefined), inputs 8 then 16 → 8×4 then 16×4.
- Backpressure: o_rdy=0 for 3 cycles on beat 2 of the 8→16 burst.
  - o_data stays 12, o_last=0 and i_rdy=0 for all 3 cycles.
  - The burst then resumes with 14,16.
- Back-to-back: i_vld held high with 3 samples → 12 consecutive o_vld beats with no bubble. i_rdy pulses only on the o_last handshake.
- Reset mid-burst: rst at beat 2 → o_vld=0 on the next cycle. A following sample 40 gives 40×4, because it is treated as the first sample.
